// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage: access sizes,
// controller states and the default data-memory depth.
package mem_access_stage_pkg;

   localparam int DEPTH_DEFAULT = 64;

   typedef enum logic [1:0] {
      SZ_BYTE     = 2'b00,
      SZ_HALF     = 2'b01,
      SZ_WORD     = 2'b10,
      SZ_WORD_ALT = 2'b11
   } size_e;

   typedef enum logic {
      ST_IDLE      = 1'b0,
      ST_LOAD_WAIT = 1'b1
   } state_e;

   // Bytes never fault; halves need addr[0]=0; words (both encodings) need addr[1:0]=0.
   function automatic logic is_misaligned(input size_e sz, input logic [1:0] lsb);
      logic mis;
      case (sz)
         SZ_BYTE: mis = 1'b0;
         SZ_HALF: mis = lsb[0];
         default: mis = |lsb;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Picks the addressed byte/half out of a captured memory word and
// zero- or sign-extends it to 32 bits.
module mem_load_align
   import mem_access_stage_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  lsb_i,
   input  size_e       size_i,
   input  logic        unsigned_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word_i[{lsb_i, 3'b000} +: 8];
      half_sel = lsb_i[1] ? word_i[31:16] : word_i[15:0];
      case (size_i)
         SZ_BYTE: data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
         SZ_HALF: data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
         default: data_o = word_i;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: single-ported data memory with byte-enable stores and
// two-cycle loads; one instruction in flight, upstream held via stall.
//
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   ST_IDLE      | accepting; non-memory ops and stores retire next edge
//   ST_LOAD_WAIT | memory word captured, align/extend and retire next edge
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        exValid,
   input  logic [31:0] exRes,
   input  logic [31:0] exStoreData,
   input  logic        exMemRead,
   input  logic        exMemWrite,
   input  logic [1:0]  exSize,
   input  logic        exUnsigned,
   input  logic        exRegWrite,
   input  logic [4:0]  exRd,
   output logic        stall,
   output logic        wbValid,
   output logic        wbRegWrite,
   output logic [4:0]  wbRd,
   output logic [31:0] wbRes,
   output logic [31:0] wbMem,
   output logic        wbMemSel,
   output logic        misalign
);

   localparam int AW = $clog2(DEPTH);

   logic [31:0] mem [DEPTH];

   state_e      state_q, state_d;
   logic        wb_valid_q, wb_valid_d;
   logic        wb_reg_write_q, wb_reg_write_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic [31:0] wb_res_q, wb_res_d;
   logic [31:0] wb_mem_q, wb_mem_d;
   logic        wb_mem_sel_q, wb_mem_sel_d;
   logic        misalign_q, misalign_d;
   logic [31:0] ld_word_q, ld_word_d;

   size_e       sz;
   logic [AW-1:0] idx;
   logic        is_mem, mis;
   logic        stall_c, mem_we;
   logic [3:0]  be;
   logic [31:0] wdata, ld_aligned;

   assign sz     = size_e'(exSize);
   assign idx    = exRes[AW+1:2];
   assign is_mem = exMemRead | exMemWrite;
   assign mis    = is_mem & is_misaligned(sz, exRes[1:0]);

   always_comb begin
      case (sz)
         SZ_BYTE: begin
            wdata = {4{exStoreData[7:0]}};
            be    = 4'b0001 << exRes[1:0];
         end
         SZ_HALF: begin
            wdata = {2{exStoreData[15:0]}};
            be    = exRes[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            wdata = exStoreData;
            be    = 4'b1111;
         end
      endcase
   end

   mem_load_align u_align (
      .word_i     (ld_word_q),
      .lsb_i      (exRes[1:0]),
      .size_i     (sz),
      .unsigned_i (exUnsigned),
      .data_o     (ld_aligned)
   );

   always_comb begin
      state_d        = state_q;
      wb_valid_d     = wb_valid_q;
      wb_reg_write_d = wb_reg_write_q;
      wb_rd_d        = wb_rd_q;
      wb_res_d       = wb_res_q;
      wb_mem_d       = wb_mem_q;
      wb_mem_sel_d   = wb_mem_sel_q;
      misalign_d     = 1'b0;
      ld_word_d      = ld_word_q;
      stall_c        = 1'b0;
      mem_we         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!exValid) begin
               wb_valid_d     = 1'b0;
               wb_reg_write_d = 1'b0;
               wb_mem_sel_d   = 1'b0;
            end else if (mis) begin
               wb_valid_d     = 1'b1;
               wb_reg_write_d = 1'b0;
               wb_mem_sel_d   = 1'b0;
               wb_res_d       = exRes;
               wb_rd_d        = exRd;
               misalign_d     = 1'b1;
            end else if (exMemWrite) begin
               mem_we         = 1'b1;
               wb_valid_d     = 1'b1;
               wb_reg_write_d = 1'b0;
               wb_mem_sel_d   = 1'b0;
               wb_res_d       = exRes;
               wb_rd_d        = exRd;
            end else if (exMemRead) begin
               // Bubble on the writeback side while the word is fetched.
               stall_c        = 1'b1;
               ld_word_d      = mem[idx];
               state_d        = ST_LOAD_WAIT;
               wb_valid_d     = 1'b0;
               wb_reg_write_d = 1'b0;
               wb_mem_sel_d   = 1'b0;
            end else begin
               wb_valid_d     = 1'b1;
               wb_reg_write_d = exRegWrite;
               wb_mem_sel_d   = 1'b0;
               wb_res_d       = exRes;
               wb_rd_d        = exRd;
            end
         end
         ST_LOAD_WAIT: begin
            // ex* are still the load here because stall held them last cycle.
            wb_valid_d     = 1'b1;
            wb_reg_write_d = exRegWrite;
            wb_mem_sel_d   = 1'b1;
            wb_mem_d       = ld_aligned;
            wb_res_d       = exRes;
            wb_rd_d        = exRd;
            state_d        = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         wb_valid_q     <= 1'b0;
         wb_reg_write_q <= 1'b0;
         wb_rd_q        <= '0;
         wb_res_q       <= '0;
         wb_mem_q       <= '0;
         wb_mem_sel_q   <= 1'b0;
         misalign_q     <= 1'b0;
         ld_word_q      <= '0;
      end else begin
         state_q        <= state_d;
         wb_valid_q     <= wb_valid_d;
         wb_reg_write_q <= wb_reg_write_d;
         wb_rd_q        <= wb_rd_d;
         wb_res_q       <= wb_res_d;
         wb_mem_q       <= wb_mem_d;
         wb_mem_sel_q   <= wb_mem_sel_d;
         misalign_q     <= misalign_d;
         ld_word_q      <= ld_word_d;
      end
   end

   // Data memory keeps its contents across reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign stall      = stall_c & rst_n;
   assign wbValid    = wb_valid_q;
   assign wbRegWrite = wb_reg_write_q;
   assign wbRd       = wb_rd_q;
   assign wbRes      = wb_res_q;
   assign wbMem      = wb_mem_q;
   assign wbMemSel   = wb_mem_sel_q;
   assign misalign   = misalign_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, reset-in-flight sequence
// and random traffic against a byte-array memory model.
module tb_mem_access_stage;

   localparam int DEPTH = 64;
   localparam int NBYTES = DEPTH * 4;

   logic        clk, rst_n;
   logic        exValid, exMemRead, exMemWrite, exUnsigned, exRegWrite;
   logic [31:0] exRes, exStoreData;
   logic [1:0]  exSize;
   logic [4:0]  exRd;
   logic        stall, wbValid, wbRegWrite, wbMemSel, misalign;
   logic [4:0]  wbRd;
   logic [31:0] wbRes, wbMem;

   mem_access_stage #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .exValid     (exValid),
      .exRes       (exRes),
      .exStoreData (exStoreData),
      .exMemRead   (exMemRead),
      .exMemWrite  (exMemWrite),
      .exSize      (exSize),
      .exUnsigned  (exUnsigned),
      .exRegWrite  (exRegWrite),
      .exRd        (exRd),
      .stall       (stall),
      .wbValid     (wbValid),
      .wbRegWrite  (wbRegWrite),
      .wbRd        (wbRd),
      .wbRes       (wbRes),
      .wbMem       (wbMem),
      .wbMemSel    (wbMemSel),
      .misalign    (misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        valid, rd, wr;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr, sdata;
      logic        rw;
      logic [4:0]  rdx;
   } op_t;

   typedef struct {
      logic        stall, valid, rw, sel, mis;
      logic [31:0] res, mem;
      logic [4:0]  rdx;
   } res_t;

   typedef struct {
      string name;
      op_t   op;
      res_t  e;
   } vec_t;

   int n_cmp = 0;
   int n_fail = 0;
   logic [7:0] mem_b [NBYTES];
   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference behaviour from the architectural rules, on a flat byte memory.
   function automatic res_t model(input op_t op);
      res_t e;
      int a, nb;
      logic [31:0] v;
      a  = int'(op.addr % NBYTES);
      nb = (op.size == 2'd0) ? 1 : (op.size == 2'd1) ? 2 : 4;
      e.stall = 1'b0; e.valid = op.valid; e.rw = 1'b0; e.sel = 1'b0; e.mis = 1'b0;
      e.res = op.addr; e.rdx = op.rdx; e.mem = 32'h0;
      if (!op.valid) return e;
      if ((op.rd || op.wr) && (a % nb != 0)) begin
         e.mis = 1'b1;
      end else if (op.wr) begin
         for (int i = 0; i < nb; i++) mem_b[a + i] = op.sdata[8*i +: 8];
      end else if (op.rd) begin
         v = 32'h0;
         for (int i = 0; i < nb; i++) v = v | (32'(mem_b[a + i]) << (8 * i));
         if (!op.uns && nb < 4 && v[8*nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
         e.stall = 1'b1; e.sel = 1'b1; e.rw = op.rw; e.mem = v;
      end else begin
         e.rw = op.rw;
      end
      return e;
   endfunction

   function automatic vec_t mk(input string nm, input logic vld, input logic rd, input logic wr,
                               input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                               input logic [31:0] sd, input logic rw, input logic [4:0] rdx,
                               input logic es, input logic ev, input logic erw, input logic esel,
                               input logic emis, input logic [31:0] emem);
      vec_t t;
      t.name = nm;
      t.op.valid = vld; t.op.rd = rd; t.op.wr = wr; t.op.size = sz; t.op.uns = uns;
      t.op.addr = addr; t.op.sdata = sd; t.op.rw = rw; t.op.rdx = rdx;
      t.e.stall = es; t.e.valid = ev; t.e.rw = erw; t.e.sel = esel; t.e.mis = emis;
      t.e.res = addr; t.e.rdx = rdx; t.e.mem = emem;
      return t;
   endfunction

   task automatic drive(input op_t op);
      exValid = op.valid; exMemRead = op.rd; exMemWrite = op.wr; exSize = op.size;
      exUnsigned = op.uns; exRes = op.addr; exStoreData = op.sdata;
      exRegWrite = op.rw; exRd = op.rdx;
   endtask

   task automatic run(input string nm, input op_t op, input res_t e);
      logic s1, s2;
      drive(op);
      #1 s1 = stall;
      @(posedge clk); #1;
      s2 = 1'b0;
      if (e.stall) begin
         s2 = stall;
         @(posedge clk); #1;
      end
      chk({nm, ".stall"}, 32'(s1), 32'(e.stall));
      if (e.stall) chk({nm, ".stall_wait"}, 32'(s2), 32'h0);
      chk({nm, ".wbValid"}, 32'(wbValid), 32'(e.valid));
      chk({nm, ".wbRegWrite"}, 32'(wbRegWrite), 32'(e.rw));
      chk({nm, ".wbMemSel"}, 32'(wbMemSel), 32'(e.sel));
      chk({nm, ".misalign"}, 32'(misalign), 32'(e.mis));
      if (e.valid) chk({nm, ".wbRd"}, 32'(wbRd), 32'(e.rdx));
      if (e.valid && !e.mis) chk({nm, ".wbRes"}, wbRes, e.res);
      if (e.sel) chk({nm, ".wbMem"}, wbMem, e.mem);
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, ".stall"}, 32'(stall), 32'h0);
      chk({nm, ".wbValid"}, 32'(wbValid), 32'h0);
      chk({nm, ".wbRegWrite"}, 32'(wbRegWrite), 32'h0);
      chk({nm, ".wbMemSel"}, 32'(wbMemSel), 32'h0);
      chk({nm, ".misalign"}, 32'(misalign), 32'h0);
      chk({nm, ".wbRd"}, 32'(wbRd), 32'h0);
      chk({nm, ".wbRes"}, wbRes, 32'h0);
      chk({nm, ".wbMem"}, wbMem, 32'h0);
   endtask

   initial begin
      op_t  op;
      res_t e, unused_e;

      rst_n = 1'b0;
      op = '{valid: 1'b0, rd: 1'b0, wr: 1'b0, size: 2'd0, uns: 1'b0,
             addr: 32'h0, sdata: 32'h0, rw: 1'b0, rdx: 5'd0};
      drive(op);
      #1 chk_all_zero("reset");
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Give every word a known value.
      for (int w = 0; w < DEPTH; w++) begin
         op = '{valid: 1'b1, rd: 1'b0, wr: 1'b1, size: 2'd2, uns: 1'b0,
                addr: 32'(w * 4), sdata: $urandom, rw: 1'b0, rdx: 5'(w)};
         e = model(op);
         run($sformatf("init%0d", w), op, e);
      end

      vecs.push_back(mk("st_w_10",     1'b1,1'b0,1'b1,2'd2,1'b0,32'h10,32'hDEADBEEF,1'b1,5'd3,  1'b0,1'b1,1'b0,1'b0,1'b0,32'h0));
      vecs.push_back(mk("ld_w_10",     1'b1,1'b1,1'b0,2'd2,1'b0,32'h10,32'h0,1'b1,5'd4,         1'b1,1'b1,1'b1,1'b1,1'b0,32'hDEADBEEF));
      vecs.push_back(mk("ld_bs_13",    1'b1,1'b1,1'b0,2'd0,1'b0,32'h13,32'h0,1'b1,5'd5,         1'b1,1'b1,1'b1,1'b1,1'b0,32'hFFFFFFDE));
      vecs.push_back(mk("ld_bu_13",    1'b1,1'b1,1'b0,2'd0,1'b1,32'h13,32'h0,1'b1,5'd5,         1'b1,1'b1,1'b1,1'b1,1'b0,32'h000000DE));
      vecs.push_back(mk("st_w_20",     1'b1,1'b0,1'b1,2'd2,1'b0,32'h20,32'hAAAAAAAA,1'b0,5'd0,  1'b0,1'b1,1'b0,1'b0,1'b0,32'h0));
      vecs.push_back(mk("st_h_22",     1'b1,1'b0,1'b1,2'd1,1'b0,32'h22,32'h55551234,1'b0,5'd0,  1'b0,1'b1,1'b0,1'b0,1'b0,32'h0));
      vecs.push_back(mk("ld_w_20",     1'b1,1'b1,1'b0,2'd2,1'b0,32'h20,32'h0,1'b1,5'd6,         1'b1,1'b1,1'b1,1'b1,1'b0,32'h1234AAAA));
      vecs.push_back(mk("ld_w_06_mis", 1'b1,1'b1,1'b0,2'd2,1'b0,32'h06,32'h0,1'b1,5'd8,         1'b0,1'b1,1'b0,1'b0,1'b1,32'h0));
      vecs.push_back(mk("alu_5",       1'b1,1'b0,1'b0,2'd2,1'b0,32'h5,32'h0,1'b1,5'd7,          1'b0,1'b1,1'b1,1'b0,1'b0,32'h0));
      vecs.push_back(mk("ld_hs_12",    1'b1,1'b1,1'b0,2'd1,1'b0,32'h12,32'h0,1'b1,5'd9,         1'b1,1'b1,1'b1,1'b1,1'b0,32'hFFFFDEAD));
      vecs.push_back(mk("ld_hu_10",    1'b1,1'b1,1'b0,2'd1,1'b1,32'h10,32'h0,1'b0,5'd9,         1'b1,1'b1,1'b0,1'b1,1'b0,32'h0000BEEF));
      vecs.push_back(mk("ld_alias",    1'b1,1'b1,1'b0,2'd2,1'b0,32'h80000110,32'h0,1'b1,5'd2,   1'b1,1'b1,1'b1,1'b1,1'b0,32'hDEADBEEF));
      vecs.push_back(mk("rdwr_st_b",   1'b1,1'b1,1'b1,2'd0,1'b0,32'h21,32'h55,1'b1,5'd10,       1'b0,1'b1,1'b0,1'b0,1'b0,32'h0));
      vecs.push_back(mk("ld_w_20b",    1'b1,1'b1,1'b0,2'd2,1'b0,32'h20,32'h0,1'b1,5'd11,        1'b1,1'b1,1'b1,1'b1,1'b0,32'h123455AA));
      vecs.push_back(mk("ld_sz3",      1'b1,1'b1,1'b0,2'd3,1'b0,32'h10,32'h0,1'b1,5'd12,        1'b1,1'b1,1'b1,1'b1,1'b0,32'hDEADBEEF));
      vecs.push_back(mk("st_h_mis",    1'b1,1'b0,1'b1,2'd1,1'b0,32'h23,32'hFFFF,1'b0,5'd0,      1'b0,1'b1,1'b0,1'b0,1'b1,32'h0));
      vecs.push_back(mk("ld_w_20c",    1'b1,1'b1,1'b0,2'd2,1'b0,32'h20,32'h0,1'b1,5'd13,        1'b1,1'b1,1'b1,1'b1,1'b0,32'h123455AA));
      vecs.push_back(mk("bubble",      1'b0,1'b1,1'b0,2'd2,1'b0,32'h20,32'h0,1'b1,5'd14,        1'b0,1'b0,1'b0,1'b0,1'b0,32'h0));
      vecs.push_back(mk("ld_bs_20",    1'b1,1'b1,1'b0,2'd0,1'b0,32'h20,32'h0,1'b1,5'd1,         1'b1,1'b1,1'b1,1'b1,1'b0,32'hFFFFFFAA));
      vecs.push_back(mk("alu_rw0",     1'b1,1'b0,1'b0,2'd0,1'b0,32'hCAFEF00D,32'h0,1'b0,5'd31,  1'b0,1'b1,1'b0,1'b0,1'b0,32'h0));

      foreach (vecs[i]) begin
         unused_e = model(vecs[i].op);
         run(vecs[i].name, vecs[i].op, vecs[i].e);
      end

      // Reset while the load sits in LOAD_WAIT: abandon it, keep memory.
      op = vecs[1].op;
      drive(op);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1 chk_all_zero("rst_in_load");
      exValid = 1'b0;
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_load.no_wb1", 32'(wbValid), 32'h0);
      @(posedge clk); #1;
      chk("rst_in_load.no_wb2", 32'(wbValid), 32'h0);
      run("post_rst_ld", vecs[1].op, vecs[1].e);

      for (int i = 0; i < 300; i++) begin
         int kind;
         kind = $urandom_range(0, 9);
         op.valid = (kind != 0);
         op.wr    = (kind >= 3 && kind <= 5) || kind == 9;
         op.rd    = kind >= 6;
         op.size  = 2'($urandom_range(0, 3));
         op.uns   = 1'($urandom_range(0, 1));
         op.addr  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 47));
         op.sdata = $urandom;
         op.rw    = 1'($urandom_range(0, 1));
         op.rdx   = 5'($urandom_range(0, 31));
         e = model(op);
         run($sformatf("rnd%0d", i), op, e);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter DEPTH, default 64, SHALL set the number of 32-bit data-memory words (power of two).
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 exValid  in  1  upstream instruction valid.
REQ-005 exRes  in  32  ALU result; byte address for loads/stores, pass-through value otherwise.
REQ-006 exStoreData  in  32  store data, byte/half in low bits.
REQ-007 exMemRead, exMemWrite  in  1 each  load / store request.
REQ-008 exSize  in  2  00 byte, 01 half, 10 word; 11 SHALL be treated as word.
REQ-009 exUnsigned  in  1  1 = zero-extend loads, 0 = sign-extend.
REQ-010 exRegWrite  in  1; exRd  in  5  writeback enable / destination.
REQ-011 stall  out  1  upstream SHALL hold all ex* inputs while high.
REQ-012 wbValid, wbRegWrite  out  1 each; wbRd  out  5.
REQ-013 wbRes  out  32  registered exRes; wbMem  out  32  aligned, extended load data.
REQ-014 wbMemSel  out  1  0 selects wbRes, 1 selects wbMem at writeback.
REQ-015 misalign  out  1  one-cycle pulse for a misaligned access.

Function
REQ-016 Word index SHALL be exRes[log2(DEPTH)+1:2]; higher address bits SHALL be ignored (aliasing wrap).
REQ-017 FSM states IDLE and LOAD_WAIT; exactly one instruction in flight.
REQ-018 IDLE, exValid=0: next edge SHALL set wbValid=0, wbRegWrite=0, wbMemSel=0, misalign=0.
REQ-019 IDLE, valid non-memory op: next edge SHALL register exRes/exRd/exRegWrite to wb*, wbMemSel=0, wbValid=1; latency 1, stall=0.
REQ-020 IDLE, valid store: memory SHALL write the enabled bytes on that edge (byte: addr[1:0] lane; half: addr[1] lanes; word: all); wb* SHALL register with wbRegWrite=0, wbMemSel=0; latency 1.
REQ-021 IDLE, valid load: stall SHALL be 1 combinationally in that cycle; next edge SHALL capture the memory word and enter LOAD_WAIT.
REQ-022 LOAD_WAIT: stall=0; next edge SHALL present wbMem (lane selected by addr[1:0], extended per exUnsigned), wbMemSel=1, wbValid=1, wbRegWrite=exRegWrite, return to IDLE; load latency 2.
REQ-023 Misaligned (half with addr[0]=1; word with addr[1:0]!=0): no memory access, no stall; next edge SHALL set misalign=1, wbValid=1, wbRegWrite=0.
REQ-024 exMemRead and exMemWrite both 1: store SHALL take priority; no load performed.
REQ-025 Store to a word followed immediately by a load of it SHALL return the new data.
REQ-026 Unused upper bits of wbMem SHALL be 0 (unsigned) or copies of the sign bit (signed).

Reset
REQ-027 rst_n low SHALL immediately force state IDLE and all outputs to 0 (stall, wbValid, wbRegWrite, wbMemSel, misalign, wbRes, wbMem, wbRd).
REQ-028 Reset during LOAD_WAIT SHALL abandon the load with no writeback produced.
REQ-029 Memory contents SHALL NOT be reset.

Structure
REQ-030 Shared package SHALL hold exSize encodings, FSM state encoding, and DEPTH default.
REQ-031 Lane selection and extension SHALL live in sub-module mem_load_align (combinational).
REQ-032 wb* outputs SHALL feed the existing writeback 2:1 mux directly (wbRes, wbMem, wbMemSel).

Verification
REQ-033 Store word 0xDEADBEEF @0x10, load word @0x10 -> stall high 1 cycle, wbMem=0xDEADBEEF, wbMemSel=1 two cycles after issue.
REQ-034 Load byte signed @0x13 of 0xDEADBEEF -> wbMem=0xFFFFFFDE; unsigned -> 0x000000DE.
REQ-035 Store half 0x1234 @0x22 over 0xAAAAAAAA, load word @0x20 -> 0x1234AAAA.
REQ-036 Load word @0x06 -> misalign=1 one cycle, wbRegWrite=0, stall never asserted.
REQ-037 ALU op exRes=0x00000005, exRd=7 -> next cycle wbRes=5, wbRd=7, wbMemSel=0, wbValid=1.
REQ-038 rst_n low mid LOAD_WAIT -> all outputs 0 immediately, no wbValid after release; prior stored data still readable.
